// File: rtl/cw_pkg.sv
`timescale 1ns/1ps
// cw_pkg: definitions shared by the CW receive decoder and the TX encoder.
//   - cw_state_e    : receive FSM states
//   - HU_* constants: half-unit thresholds for element and gap classification
//   - CHAR_UNKNOWN  : character index reported for an unrecognised pattern
//   - ITU_CODE/LEN  : ITU Morse table, index 0-25 = A-Z, 26-35 = '0'-'9'.
//                     bit0 = first element, 1 = dash, unused bits 0.
package cw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE
    } cw_state_e;

    localparam logic [3:0] HU_DASH = 4'd4;
    localparam logic [3:0] HU_ERR  = 4'd10;
    localparam logic [3:0] HU_CHAR = 4'd4;
    localparam logic [3:0] HU_WORD = 4'd10;

    localparam logic [5:0] CHAR_UNKNOWN = 6'd63;

    localparam int N_CHARS = 36;

    localparam logic [4:0] ITU_CODE [N_CHARS] = '{
        5'b00010, 5'b00001, 5'b00101, 5'b00001, 5'b00000, 5'b00100, // A-F
        5'b00011, 5'b00000, 5'b00000, 5'b01110, 5'b00101, 5'b00010, // G-L
        5'b00011, 5'b00001, 5'b00111, 5'b00110, 5'b01011, 5'b00010, // M-R
        5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b00110, 5'b01001, // S-X
        5'b01101, 5'b00011,                                         // Y-Z
        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000,           // 0-4
        5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111            // 5-9
    };

    localparam logic [2:0] ITU_LEN [N_CHARS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4,
        3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4,
        3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3,
        3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4,
        3'd4, 3'd4,
        3'd5, 3'd5, 3'd5, 3'd5, 3'd5,
        3'd5, 3'd5, 3'd5, 3'd5, 3'd5
    };

endpackage

// File: rtl/cw_char_lut.sv
`timescale 1ns/1ps
// cw_char_lut: combinational Morse pattern -> character index lookup.
//   sym_code : elements, bit0 = first, 1 = dash (unused bits must be 0)
//   sym_len  : element count 1..5
//   char_idx : 0-25 = A-Z, 26-35 = '0'-'9', CHAR_UNKNOWN otherwise
module cw_char_lut (
    input  logic [4:0] sym_code,
    input  logic [2:0] sym_len,
    output logic [5:0] char_idx
);
    import cw_pkg::*;

    always_comb begin
        char_idx = CHAR_UNKNOWN;
        for (int i = 0; i < N_CHARS; i++) begin
            if (sym_code == ITU_CODE[i] && sym_len == ITU_LEN[i]) begin
                char_idx = 6'(i);
            end
        end
    end

endmodule

// File: rtl/cw_rx_decoder.sv
`timescale 1ns/1ps
// cw_rx_decoder: CW (Morse) receiver. Synchronises and deglitches a keyed
// on/off line, times marks and spaces in half-unit ticks, classifies dots and
// dashes and emits one decoded character per inter-character gap.
//   CLK       : system clock
//   RST       : synchronous active-high reset
//   RX_IN     : raw keyed line (1 = mark), asynchronous
//   KEY_LED   : filtered line level
//   SYM_VALID : one-cycle pulse, character decoded
//   SYM_CODE  : elements of the last character, bit0 first, 1 = dash
//   SYM_LEN   : element count of the last character
//   CHAR_IDX  : 0-25 A-Z, 26-35 '0'-'9', 63 unknown
//   WORD_GAP  : one-cycle pulse, word space detected
//   ERR       : one-cycle pulse, overlong mark or more than 5 elements
module cw_rx_decoder #(
    parameter int UNIT_CYCLES   = 2_500_000,
    parameter int GLITCH_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    output logic       KEY_LED,
    output logic       SYM_VALID,
    output logic [4:0] SYM_CODE,
    output logic [2:0] SYM_LEN,
    output logic [5:0] CHAR_IDX,
    output logic       WORD_GAP,
    output logic       ERR
);
    import cw_pkg::*;

    localparam int HALF_CYCLES = UNIT_CYCLES / 2;
    localparam int PRE_W       = $clog2(HALF_CYCLES);
    localparam int GL_W        = $clog2(GLITCH_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_CYCLES - 1);
    localparam logic [GL_W-1:0]  GL_LAST  = GL_W'(GLITCH_CYCLES - 1);

    logic             sync_p0, sync_p1;
    logic             key_lvl;
    logic [GL_W-1:0]  glitch_cnt;
    logic             key_flip, key_rise, key_fall;
    logic [PRE_W-1:0] pre_cnt;
    logic [3:0]       hu, hu_inc;
    logic             tick;
    cw_state_e        state, state_nx;
    logic [4:0]       elem_code;
    logic [2:0]       elem_cnt;
    logic             char_bad;
    logic             elem_dash;
    logic             sym_fire, word_fire, err_fire;
    logic             elem_push, bad_set, buf_clr;
    logic [5:0]       lut_idx;

    // Stage p0/p1: two-flop synchroniser, then the glitch filter. The filter
    // flips on the GLITCH_CYCLES-th consecutive cycle of disagreement.
    assign key_flip = (sync_p1 != key_lvl) && (glitch_cnt == GL_LAST);
    assign key_rise = key_flip & ~key_lvl;
    assign key_fall = key_flip &  key_lvl;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            key_lvl    <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            sync_p0 <= RX_IN;
            sync_p1 <= sync_p0;
            if (sync_p1 == key_lvl || key_flip) begin
                glitch_cnt <= '0;
            end else begin
                glitch_cnt <= glitch_cnt + GL_W'(1);
            end
            if (key_flip) begin
                key_lvl <= ~key_lvl;
            end
        end
    end

    assign KEY_LED = key_lvl;

    // Timing stage: half-unit prescaler and saturating half-unit counter,
    // both restarted by every filtered edge.
    assign tick   = (pre_cnt == PRE_LAST);
    assign hu_inc = hu + 4'd1;

    always_ff @(posedge CLK) begin
        if (RST || key_flip) begin
            pre_cnt <= '0;
            hu      <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            if (hu != 4'd15) begin
                hu <= hu_inc;
            end
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Classification / FSM stage. An edge always wins over a coincident tick,
    // so every tick-driven branch sits behind the edge test.
    assign elem_dash = (hu >= HU_DASH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sym_fire  = 1'b0;
        word_fire = 1'b0;
        err_fire  = 1'b0;
        elem_push = 1'b0;
        bad_set   = 1'b0;
        buf_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_rise) begin
                    state_nx = ST_MARK;
                end
            end
            ST_MARK: begin
                if (key_fall) begin
                    state_nx = ST_SPACE;
                    // A bad character (overlong mark) never accepts more elements.
                    if (!char_bad) begin
                        if (elem_cnt == 3'd5) begin
                            bad_set = 1'b1;
                        end else begin
                            elem_push = 1'b1;
                        end
                    end
                end else if (tick && hu_inc == HU_ERR) begin
                    err_fire = 1'b1;
                    bad_set  = 1'b1;
                end
            end
            ST_SPACE: begin
                if (key_rise) begin
                    state_nx = ST_MARK;
                end else if (tick && hu_inc == HU_CHAR) begin
                    buf_clr = 1'b1;
                    if (char_bad) begin
                        err_fire = 1'b1;
                    end else if (elem_cnt != 3'd0) begin
                        sym_fire = 1'b1;
                    end
                end else if (tick && hu_inc == HU_WORD) begin
                    word_fire = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    cw_char_lut u_lut (
        .sym_code (elem_code),
        .sym_len  (elem_cnt),
        .char_idx (lut_idx)
    );

    // Output stage: element buffer and registered pulses / character fields.
    always_ff @(posedge CLK) begin
        if (RST) begin
            elem_code <= '0;
            elem_cnt  <= '0;
            char_bad  <= 1'b0;
            SYM_VALID <= 1'b0;
            WORD_GAP  <= 1'b0;
            ERR       <= 1'b0;
            SYM_CODE  <= '0;
            SYM_LEN   <= '0;
            CHAR_IDX  <= '0;
        end else begin
            SYM_VALID <= sym_fire;
            WORD_GAP  <= word_fire;
            ERR       <= err_fire;
            if (buf_clr) begin
                elem_code <= '0;
                elem_cnt  <= '0;
                char_bad  <= 1'b0;
            end else begin
                if (elem_push) begin
                    elem_code <= elem_code | (5'(elem_dash) << elem_cnt);
                    elem_cnt  <= elem_cnt + 3'd1;
                end
                if (bad_set) begin
                    char_bad <= 1'b1;
                end
            end
            if (sym_fire) begin
                SYM_CODE <= elem_code;
                SYM_LEN  <= elem_cnt;
                CHAR_IDX <= lut_idx;
            end
        end
    end

endmodule

// File: tb/tb_cw_rx_decoder.sv
`timescale 1ns/1ps
// Bench for cw_rx_decoder with UNIT_CYCLES=100, GLITCH_CYCLES=4.
// Expected pulses come from a timeline model working on mark/space durations
// and a Morse-string character table.
module tb_cw_rx_decoder;

    localparam int UNIT = 100;
    localparam int GL   = 4;
    localparam int HALF = UNIT / 2;
    localparam int LAT  = 2 + GL;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b0;
    logic       KEY_LED, SYM_VALID, WORD_GAP, ERR;
    logic [4:0] SYM_CODE;
    logic [2:0] SYM_LEN;
    logic [5:0] CHAR_IDX;

    cw_rx_decoder #(.UNIT_CYCLES(UNIT), .GLITCH_CYCLES(GL)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .KEY_LED   (KEY_LED),
        .SYM_VALID (SYM_VALID),
        .SYM_CODE  (SYM_CODE),
        .SYM_LEN   (SYM_LEN),
        .CHAR_IDX  (CHAR_IDX),
        .WORD_GAP  (WORD_GAP),
        .ERR       (ERR)
    );

    always #10 CLK = ~CLK;

    int unsigned stamp = 0;
    always @(posedge CLK) stamp <= stamp + 1;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int         t;
        int         kind;   // 0 = SYM_VALID, 1 = WORD_GAP, 2 = ERR
        logic [4:0] code;
        logic [2:0] len;
        logic [5:0] idx;
    } evt_t;

    typedef struct {
        string      morse;
        logic [4:0] code;
        logic [2:0] len;
        logic [5:0] idx;
    } vec_t;

    evt_t exp_q[$];
    int   seg_mark[$];
    int   seg_space[$];

    string morse_tab[36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."
    };

    logic [4:0] last_code;
    logic [2:0] last_len;
    logic [5:0] last_idx;
    int         sym_seen  = 0;
    int         word_seen = 0;
    int         err_seen  = 0;
    int         key_edges = 0;
    logic       key_prev  = 1'b0;

    task automatic check(input string name, input longint got, input longint want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0d)", name, got, want, stamp);
        end
    endtask

    function automatic logic [5:0] ref_idx(input logic [4:0] code, input int len);
        string s;
        s = "";
        for (int i = 0; i < len; i++) begin
            if (code[i]) s = {s, "-"};
            else         s = {s, "."};
        end
        ref_idx = 6'd63;
        for (int i = 0; i < 36; i++) begin
            if (morse_tab[i] == s) ref_idx = 6'(i);
        end
    endfunction

    task automatic push_evt(input int t, input int kind, input logic [4:0] code,
                            input int len);
        evt_t e;
        e.t    = t;
        e.kind = kind;
        e.code = code;
        e.len  = 3'(len);
        e.idx  = (kind == 0) ? ref_idx(code, len) : 6'd0;
        exp_q.push_back(e);
    endtask

    // Timeline model: t0 is the stamp of the first filtered rising edge.
    task automatic model_run(input int t0);
        int         t;
        int         cnt;
        bit         bad;
        logic [4:0] code;
        int         d, s;
        t = t0; cnt = 0; bad = 0; code = '0;
        foreach (seg_mark[i]) begin
            d = seg_mark[i];
            s = seg_space[i];
            if (d > 10 * HALF) begin
                push_evt(t + 10 * HALF, 2, 5'd0, 0);
                bad = 1;
            end else if (!bad) begin
                if (cnt == 5) bad = 1;
                else begin
                    if ((d - 1) / HALF >= 4) code[cnt] = 1'b1;
                    cnt++;
                end
            end
            t += d;
            if (s > 4 * HALF) begin
                if (bad)          push_evt(t + 4 * HALF, 2, 5'd0, 0);
                else if (cnt > 0) push_evt(t + 4 * HALF, 0, code, cnt);
                cnt = 0; bad = 0; code = '0;
            end
            if (s > 10 * HALF) push_evt(t + 10 * HALF, 1, 5'd0, 0);
            t += s;
        end
    endtask

    task automatic got_evt(input int kind);
        evt_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_pulse kind=%0d at=%0d want=none", kind, stamp);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", kind, e.kind);
            check("evt_time", stamp, e.t);
            if (kind == 0) begin
                check("evt_code", SYM_CODE, e.code);
                check("evt_len", SYM_LEN, e.len);
                check("evt_idx", CHAR_IDX, e.idx);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (KEY_LED != key_prev) key_edges++;
            key_prev = KEY_LED;
            if (SYM_VALID) begin
                sym_seen++;
                last_code = SYM_CODE;
                last_len  = SYM_LEN;
                last_idx  = CHAR_IDX;
                got_evt(0);
            end
            if (WORD_GAP) begin word_seen++; got_evt(1); end
            if (ERR)      begin err_seen++;  got_evt(2); end
        end
    endtask

    task automatic hold(input bit lvl, input int n, input bit glitch);
        if (glitch) begin
            RX_IN = lvl;  repeat (n / 2 - 1) @(negedge CLK);
            RX_IN = ~lvl; repeat (2) @(negedge CLK);
            RX_IN = lvl;  repeat (n - n / 2 - 1) @(negedge CLK);
        end else begin
            RX_IN = lvl;  repeat (n) @(negedge CLK);
        end
    endtask

    task automatic scenario(input bit glitch);
        model_run(int'(stamp) + LAT);
        foreach (seg_mark[i]) begin
            hold(1'b1, seg_mark[i], glitch);
            hold(1'b0, seg_space[i], glitch);
        end
        repeat (20) @(negedge CLK);
        check("leftover_events", exp_q.size(), 0);
        exp_q.delete();
        seg_mark.delete();
        seg_space.delete();
    endtask

    task automatic add_seg(input int m, input int s);
        seg_mark.push_back(m);
        seg_space.push_back(s);
    endtask

    task automatic load_morse(input string m, input int last_space);
        for (int i = 0; i < m.len(); i++) begin
            add_seg((m[i] == "-") ? 3 * UNIT : UNIT,
                    (i == m.len() - 1) ? last_space : UNIT);
        end
    endtask

    vec_t vecs[7];
    int   s0, w0, e0, k0;

    initial begin
        #4_000_000;
        $display("FAIL watchdog at=%0d want=finish", stamp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{".-",    5'b00010, 3'd2, 6'd0};
        vecs[1] = '{"-.-",   5'b00101, 3'd3, 6'd10};
        vecs[2] = '{"-----", 5'b11111, 3'd5, 6'd26};
        vecs[3] = '{".....", 5'b00000, 3'd5, 6'd31};
        vecs[4] = '{"--.-",  5'b01011, 3'd4, 6'd16};
        vecs[5] = '{"--...", 5'b00011, 3'd5, 6'd33};
        vecs[6] = '{"..--",  5'b01100, 3'd4, 6'd63};

        fork monitor(); join_none

        RST = 1'b1; RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_key_led", KEY_LED, 0);
        check("rst_sym_valid", SYM_VALID, 0);
        check("rst_sym_code", SYM_CODE, 0);
        check("rst_sym_len", SYM_LEN, 0);
        check("rst_char_idx", CHAR_IDX, 0);
        check("rst_word_gap", WORD_GAP, 0);
        check("rst_err", ERR, 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // Table of single characters, each ending in a word gap.
        for (int v = 0; v < 7; v++) begin
            s0 = sym_seen; w0 = word_seen;
            load_morse(vecs[v].morse, 7 * UNIT);
            scenario(1'b0);
            check("tab_sym_count", sym_seen - s0, 1);
            check("tab_word_count", word_seen - w0, 1);
            check("tab_code", last_code, vecs[v].code);
            check("tab_len", last_len, vecs[v].len);
            check("tab_idx", last_idx, vecs[v].idx);
        end

        // E then T within one word.
        s0 = sym_seen; w0 = word_seen;
        add_seg(UNIT, 3 * UNIT);
        add_seg(3 * UNIT, 7 * UNIT);
        scenario(1'b0);
        check("et_sym_count", sym_seen - s0, 2);
        check("et_word_count", word_seen - w0, 1);
        check("et_last_idx", last_idx, 19);
        check("et_last_code", last_code, 5'b00001);

        // E with 2-cycle glitches in mark and space.
        s0 = sym_seen; k0 = key_edges;
        add_seg(UNIT, 7 * UNIT);
        scenario(1'b1);
        check("glitch_key_edges", key_edges - k0, 2);
        check("glitch_sym_count", sym_seen - s0, 1);
        check("glitch_idx", last_idx, 4);

        // Overlong mark.
        s0 = sym_seen; e0 = err_seen;
        add_seg(12 * UNIT, 7 * UNIT);
        scenario(1'b0);
        check("long_err_count", err_seen - e0, 2);
        check("long_sym_count", sym_seen - s0, 0);

        // Six dots, then '5'.
        s0 = sym_seen; e0 = err_seen;
        for (int i = 0; i < 6; i++) add_seg(UNIT, (i == 5) ? 3 * UNIT : UNIT);
        load_morse(".....", 7 * UNIT);
        scenario(1'b0);
        check("six_err_count", err_seen - e0, 1);
        check("six_sym_count", sym_seen - s0, 1);
        check("five_idx", last_idx, 31);
        check("five_code", last_code, 5'b00000);
        check("five_len", last_len, 5);

        // Exact threshold durations: dot/dash, intra/char gap, dash/overlong.
        add_seg(200, 200);
        add_seg(201, 201);
        add_seg(500, 500);
        add_seg(501, 700);
        scenario(1'b0);

        // Reset mid-'K' after two elements.
        s0 = sym_seen; w0 = word_seen; e0 = err_seen;
        hold(1'b1, 3 * UNIT, 1'b0);
        hold(1'b0, UNIT, 1'b0);
        hold(1'b1, UNIT, 1'b0);
        hold(1'b0, HALF, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_key_led", KEY_LED, 0);
        check("midrst_sym_len", SYM_LEN, 0);
        check("midrst_sym_code", SYM_CODE, 0);
        check("midrst_char_idx", CHAR_IDX, 0);
        check("midrst_pulses", {SYM_VALID, WORD_GAP, ERR}, 0);
        RST = 1'b0;
        repeat (8 * UNIT) @(negedge CLK);
        check("midrst_no_pulses", (sym_seen - s0) + (word_seen - w0) + (err_seen - e0), 0);
        load_morse("-.-", 7 * UNIT);
        scenario(1'b0);
        check("k_code", last_code, 5'b00101);
        check("k_len", last_len, 3);
        check("k_idx", last_idx, 10);

        // Random keying against the timeline model.
        for (int r = 0; r < 6; r++) begin
            int ne;
            ne = int'($urandom_range(1, 6));
            for (int i = 0; i < ne; i++) begin
                add_seg(int'($urandom_range(40, 600)),
                        (i == ne - 1) ? 7 * UNIT : int'($urandom_range(40, 600)));
            end
            scenario(1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cw_rx_decoder.md
Name: cw_rx_decoder

Overview:
- Receive-side counterpart of the CW (Morse) transmitter: samples a keyed on/off line (GPIO input from a TX board or a hand key) and reconstructs characters.
- Pipeline: synchroniser and glitch filter, then mark/space timing in half-unit ticks, then dot/dash classification, then element accumulation.
- Emits one decoded character per inter-character gap, plus word-gap and error pulses. Downstream display logic drives HEX0 from its output.

Parameters:
- UNIT_CYCLES, 2_500_000, clock cycles per Morse unit (dot length); must be even and >=8.
- GLITCH_CYCLES, 1000, consecutive stable samples required before the filtered level changes (>=1).

Ports:
- CLK  input  1  system clock (50 MHz on board)
- RST  input  1  synchronous, active-high reset
- RX_IN  input  1  raw keyed line, 1 = carrier/mark; asynchronous
- KEY_LED  output  1  filtered line level
- SYM_VALID  output  1  one-cycle pulse: character decoded
- SYM_CODE  output  5  elements, bit0 = first element, 1 = dash, 0 = dot; unused bits 0
- SYM_LEN  output  3  element count, 1..5
- CHAR_IDX  output  6  0-25 = A-Z, 26-35 = '0'-'9', 63 = unknown pattern
- WORD_GAP  output  1  one-cycle pulse: word space detected
- ERR  output  1  one-cycle pulse: overlong mark or more than 5 elements

Behaviour:
- Reset (RST high at a CLK edge): all outputs 0, CHAR_IDX = 0, synchroniser and filter = 0, state IDLE, counters cleared, element buffer empty. Reset mid-character discards the character with no pulses.
- RX_IN passes through a 2-FF synchroniser. The filtered level flips only after the synchronised value differs from it for GLITCH_CYCLES consecutive cycles. Raw edge to KEY_LED latency is 2+GLITCH_CYCLES cycles.
- Half-unit tick prescaler:
  - period UNIT_CYCLES/2;
  - cleared on every filtered edge;
  - drives an element counter HU[3:0] that saturates at 15 and is cleared on every filtered edge.
- States: IDLE, MARK, SPACE.
  - IDLE: filtered rising edge -> MARK. No pulses are generated in IDLE.
  - MARK, on falling edge:
    - HU<4: dot;
    - 4<=HU<10: dash;
    - the element is appended (count increments), then -> SPACE.
    - If the count is already 5, set the char-bad flag and do not append.
  - MARK, overlong: when HU reaches 10 while in MARK, pulse ERR once and set char-bad. The element is not appended on release.
  - SPACE:
    - rising edge with HU<4 -> MARK (intra-character gap).
    - HU reaches 4: character end. If count>0 and not bad, pulse SYM_VALID. If bad, pulse ERR instead (once). Then clear the buffer and flag.
    - HU reaches 10: pulse WORD_GAP, -> IDLE.
    - Rising edge with 4<=HU<10 -> MARK (new character in the same word).
- SYM_CODE, SYM_LEN and CHAR_IDX are registered together with SYM_VALID and hold until the next SYM_VALID.
- Timing:
  - SYM_VALID occurs on the cycle the 4th half-unit tick of the space is counted, i.e. 2*UNIT_CYCLES cycles after the filtered falling edge.
  - WORD_GAP occurs 5*UNIT_CYCLES cycles after that edge.
- Simultaneous events: a filtered edge on the same cycle as a threshold tick has priority. The edge is processed and the tick is ignored.
- If a character is pending and the line stays in space, the SYM_VALID/ERR pulse always precedes WORD_GAP by 3*UNIT_CYCLES cycles.

Decomposition:
- Shared package cw_pkg holds:
  - state enum;
  - thresholds HU_DASH=4, HU_ERR=10, HU_CHAR=4, HU_WORD=10;
  - CHAR_UNKNOWN=63;
  - ITU code table constants, shared with the TX encoder.
- One sub-module, cw_char_lut: combinational (SYM_CODE, SYM_LEN) -> CHAR_IDX lookup.
- Filter, timing and FSM stay in the top.

Test Plan (UNIT_CYCLES=100, GLITCH_CYCLES=4, CLK period 20 ns):
1. 'A': mark 100 cycles, space 100, mark 300, then idle -> SYM_VALID once with SYM_CODE=00010, SYM_LEN=2, CHAR_IDX=0. WORD_GAP follows 300 cycles after SYM_VALID.
2. 'E', then 'T' after a 300-cycle space -> two SYM_VALID pulses with (00000, 1, 4) then (00001, 1, 19); no WORD_GAP between them.
3. 'E' with 2-cycle glitches injected mid-mark and mid-space -> KEY_LED unaffected; single decode of E.
4. Mark held 1200 cycles -> ERR pulses once at HU=10; on release, ERR pulses once more at character end; no SYM_VALID.
5. Six dots at 100/100 timing -> no SYM_VALID; one ERR at character end. A following '5' (five dots) decodes as CHAR_IDX=31, SYM_CODE=00000, SYM_LEN=5.
6. RST asserted mid-'K' after 2 elements -> all outputs 0 next cycle. A subsequent clean 'K' decodes as SYM_CODE=00101, SYM_LEN=3, CHAR_IDX=10.
